// File: rtl/mc_controller_pkg.sv
// Shared definitions for the multicycle controller: state encodings, opcodes,
// ALU/mux select codes and the control-word bundle.
package mc_controller_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_FETCH  = 4'd0;
  localparam state_t ST_DECODE = 4'd1;
  localparam state_t ST_MEMADR = 4'd2;
  localparam state_t ST_MEMRD  = 4'd3;
  localparam state_t ST_MEMWB  = 4'd4;
  localparam state_t ST_MEMWR  = 4'd5;
  localparam state_t ST_EXEC   = 4'd6;
  localparam state_t ST_ALUWB  = 4'd7;
  localparam state_t ST_BRANCH = 4'd8;
  localparam state_t ST_IEXEC  = 4'd9;
  localparam state_t ST_IWB    = 4'd10;
  localparam state_t ST_JUMP   = 4'd11;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_ITYPE = 2'b10;
  localparam logic [1:0] ALUOP_RTYPE = 2'b11;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       iord;
    logic       alusrca;
    logic       regdst;
    logic       memtoreg;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = ctrl_t'(15'd0);

endpackage

// File: rtl/mc_output_decode.sv
// Combinational state -> control-word decode. JUMP decode present only
// when MC_CONTROLLER_JUMP_EN is defined.
module mc_output_decode
  import mc_controller_pkg::*;
(
  input  logic [3:0] state,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  // Moore decode; irwrite/pcwrite in FETCH are the only mem_ready-dependent outputs
  always_comb begin
    ctrl = CTRL_IDLE;
    case (state)
      ST_FETCH: begin
        ctrl.alusrcb = SRCB_FOUR;
        ctrl.aluop   = ALUOP_ADD;
        ctrl.pcsrc   = PCSRC_ALU;
        ctrl.irwrite = mem_ready;
        ctrl.pcwrite = mem_ready;
      end
      ST_DECODE: begin
        ctrl.alusrcb = SRCB_IMMSH;
        ctrl.aluop   = ALUOP_ADD;
      end
      ST_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      ST_MEMRD:  ctrl.iord = 1'b1;
      ST_MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      ST_MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      ST_EXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_REG;
        ctrl.aluop   = ALUOP_RTYPE;
      end
      ST_ALUWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_REG;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.pcsrc   = PCSRC_ALUOUT;
        ctrl.branch  = 1'b1;
      end
      ST_IEXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_ITYPE;
      end
      ST_IWB:    ctrl.regwrite = 1'b1;
`ifdef MC_CONTROLLER_JUMP_EN
      ST_JUMP: begin
        ctrl.pcsrc   = PCSRC_JUMP;
        ctrl.pcwrite = 1'b1;
      end
`endif
      default:   ctrl = CTRL_IDLE;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle CPU main controller: state register, next-state logic and output
// decode. Define MC_CONTROLLER_JUMP_EN to support the j instruction.
module mc_controller
  import mc_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       branch,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       alusrca,
  output logic       regdst,
  output logic       memtoreg,
  output logic       illegal_op,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic [3:0] state
);

  state_t state_r;
  state_t next_state_s;
  state_t dec_state_s;
  logic   known_op_s;
  logic   dec_ready_s;
  ctrl_t  ctrl_s;

  // Next-state selection; known_op_s drops only for an unrecognised opcode in DECODE
  always_comb begin
    next_state_s = ST_FETCH;
    known_op_s   = 1'b1;
    case (state_r)
      ST_FETCH:  next_state_s = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:                     next_state_s = ST_MEMADR;
          OP_RTYPE:                         next_state_s = ST_EXEC;
          OP_BEQ:                           next_state_s = ST_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: next_state_s = ST_IEXEC;
`ifdef MC_CONTROLLER_JUMP_EN
          OP_J:                             next_state_s = ST_JUMP;
`endif
          default: begin
            next_state_s = ST_FETCH;
            known_op_s   = 1'b0;
          end
        endcase
      end
      ST_MEMADR: next_state_s = (opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD:  next_state_s = mem_ready ? ST_MEMWB : ST_MEMRD;
      ST_MEMWB:  next_state_s = ST_FETCH;
      ST_MEMWR:  next_state_s = mem_ready ? ST_FETCH : ST_MEMWR;
      ST_EXEC:   next_state_s = ST_ALUWB;
      ST_ALUWB:  next_state_s = ST_FETCH;
      ST_BRANCH: next_state_s = ST_FETCH;
      ST_IEXEC:  next_state_s = ST_IWB;
      ST_IWB:    next_state_s = ST_FETCH;
      default:   next_state_s = ST_FETCH;
    endcase
  end

  // State register with dominant synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Reset presents FETCH Moore values with the write strobes held low
  assign dec_state_s = reset ? ST_FETCH : state_r;
  assign dec_ready_s = mem_ready & ~reset;

  mc_output_decode u_decode (
    .state     (dec_state_s),
    .mem_ready (dec_ready_s),
    .ctrl      (ctrl_s)
  );

  assign pcwrite    = ctrl_s.pcwrite;
  assign branch     = ctrl_s.branch;
  assign irwrite    = ctrl_s.irwrite;
  assign memwrite   = ctrl_s.memwrite;
  assign regwrite   = ctrl_s.regwrite;
  assign iord       = ctrl_s.iord;
  assign alusrca    = ctrl_s.alusrca;
  assign regdst     = ctrl_s.regdst;
  assign memtoreg   = ctrl_s.memtoreg;
  assign alusrcb    = ctrl_s.alusrcb;
  assign pcsrc      = ctrl_s.pcsrc;
  assign aluop      = ctrl_s.aluop;
  assign illegal_op = ~reset & ~known_op_s;
  assign state      = dec_state_s;

endmodule

// File: tb/tb_mc_controller.sv
// Directed self-checking bench for mc_controller; outputs sampled on the
// falling clock edge, inputs changed there too.
module tb_mc_controller;
  import mc_controller_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pcwrite, branch, irwrite, memwrite, regwrite, iord;
  logic       alusrca, regdst, memtoreg, illegal_op;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  mc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .pcwrite    (pcwrite),
    .branch     (branch),
    .irwrite    (irwrite),
    .memwrite   (memwrite),
    .regwrite   (regwrite),
    .iord       (iord),
    .alusrca    (alusrca),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .illegal_op (illegal_op),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .aluop      (aluop),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mem_ready = 1'b1; opcode = 6'b000000;

    // reset with mem_ready high: FETCH Moore values, write strobes low
    step();
    chk("rst_state",    {4'd0, state}, 8'd0);
    chk("rst_alusrcb",  {6'd0, alusrcb}, 8'd1);
    chk("rst_irwrite",  {7'd0, irwrite}, 8'd0);
    chk("rst_pcwrite",  {7'd0, pcwrite}, 8'd0);
    chk("rst_regwrite", {7'd0, regwrite}, 8'd0);
    chk("rst_illegal",  {7'd0, illegal_op}, 8'd0);

    // FETCH stall with mem_ready low
    reset = 1'b0; mem_ready = 1'b0;
    #1;
    chk("fetch_stall_irwrite", {7'd0, irwrite}, 8'd0);
    step();
    chk("fetch_stall_state", {4'd0, state}, 8'd0);
    mem_ready = 1'b1;
    #1;
    chk("fetch_irwrite", {7'd0, irwrite}, 8'd1);
    chk("fetch_pcwrite", {7'd0, pcwrite}, 8'd1);

    // R-type: FETCH, DECODE, EXEC, ALUWB, FETCH
    step();
    chk("r_decode_state",   {4'd0, state}, {4'd0, ST_DECODE});
    chk("r_decode_alusrcb", {6'd0, alusrcb}, 8'd3);
    chk("r_decode_irwrite", {7'd0, irwrite}, 8'd0);
    step();
    chk("r_exec_state",    {4'd0, state}, {4'd0, ST_EXEC});
    chk("r_exec_aluop",    {6'd0, aluop}, 8'd3);
    chk("r_exec_alusrca",  {7'd0, alusrca}, 8'd1);
    chk("r_exec_alusrcb",  {6'd0, alusrcb}, 8'd0);
    chk("r_exec_regwrite", {7'd0, regwrite}, 8'd0);
    chk("r_exec_regdst",   {7'd0, regdst}, 8'd0);
    step();
    chk("r_aluwb_state",    {4'd0, state}, {4'd0, ST_ALUWB});
    chk("r_aluwb_regwrite", {7'd0, regwrite}, 8'd1);
    chk("r_aluwb_regdst",   {7'd0, regdst}, 8'd1);
    step();
    chk("r_done_state",    {4'd0, state}, 8'd0);
    chk("r_done_regwrite", {7'd0, regwrite}, 8'd0);

    // lw with three stall cycles in MEMRD
    opcode = 6'b100011;
    step();
    chk("lw_decode_state", {4'd0, state}, {4'd0, ST_DECODE});
    step();
    chk("lw_memadr_state",   {4'd0, state}, {4'd0, ST_MEMADR});
    chk("lw_memadr_alusrcb", {6'd0, alusrcb}, 8'd2);
    chk("lw_memadr_alusrca", {7'd0, alusrca}, 8'd1);
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("lw_memrd_state", {4'd0, state}, {4'd0, ST_MEMRD});
      chk("lw_memrd_iord",  {7'd0, iord}, 8'd1);
      if (i == 3) mem_ready = 1'b1;
    end
    step();
    chk("lw_memwb_state",    {4'd0, state}, {4'd0, ST_MEMWB});
    chk("lw_memwb_memtoreg", {7'd0, memtoreg}, 8'd1);
    chk("lw_memwb_regwrite", {7'd0, regwrite}, 8'd1);
    chk("lw_memwb_regdst",   {7'd0, regdst}, 8'd0);
    step();
    chk("lw_done_state", {4'd0, state}, 8'd0);

    // sw with two stall cycles: memwrite high for exactly three cycles
    opcode = 6'b101011;
    step();
    step();
    chk("sw_memadr_state", {4'd0, state}, {4'd0, ST_MEMADR});
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("sw_memwr_state",    {4'd0, state}, {4'd0, ST_MEMWR});
      chk("sw_memwr_memwrite", {7'd0, memwrite}, 8'd1);
      if (i == 2) mem_ready = 1'b1;
    end
    step();
    chk("sw_done_state",    {4'd0, state}, 8'd0);
    chk("sw_done_memwrite", {7'd0, memwrite}, 8'd0);

    // unknown opcode: one-cycle illegal_op pulse in DECODE
    opcode = 6'b111111;
    step();
    chk("ill_decode_state",    {4'd0, state}, {4'd0, ST_DECODE});
    chk("ill_decode_illegal",  {7'd0, illegal_op}, 8'd1);
    chk("ill_decode_regwrite", {7'd0, regwrite}, 8'd0);
    chk("ill_decode_memwrite", {7'd0, memwrite}, 8'd0);
    step();
    chk("ill_done_state",   {4'd0, state}, 8'd0);
    chk("ill_done_illegal", {7'd0, illegal_op}, 8'd0);

    // j: JUMP when enabled, otherwise illegal
    opcode = 6'b000010;
    step();
    chk("j_decode_state", {4'd0, state}, {4'd0, ST_DECODE});
`ifdef MC_CONTROLLER_JUMP_EN
    chk("j_decode_illegal", {7'd0, illegal_op}, 8'd0);
    step();
    chk("j_jump_state",   {4'd0, state}, {4'd0, ST_JUMP});
    chk("j_jump_pcsrc",   {6'd0, pcsrc}, 8'd2);
    chk("j_jump_pcwrite", {7'd0, pcwrite}, 8'd1);
`else
    chk("j_decode_illegal", {7'd0, illegal_op}, 8'd1);
`endif
    step();
    chk("j_done_state", {4'd0, state}, 8'd0);

    // addi: IEXEC then IWB
    opcode = 6'b001000;
    step();
    step();
    chk("i_iexec_state",   {4'd0, state}, {4'd0, ST_IEXEC});
    chk("i_iexec_aluop",   {6'd0, aluop}, 8'd2);
    chk("i_iexec_alusrcb", {6'd0, alusrcb}, 8'd2);
    step();
    chk("i_iwb_state",    {4'd0, state}, {4'd0, ST_IWB});
    chk("i_iwb_regwrite", {7'd0, regwrite}, 8'd1);
    chk("i_iwb_regdst",   {7'd0, regdst}, 8'd0);
    step();
    chk("i_done_state", {4'd0, state}, 8'd0);

    // reset during a MEMWR stall, then beq
    opcode = 6'b101011;
    step();
    step();
    mem_ready = 1'b0;
    step();
    chk("rs_memwr_state", {4'd0, state}, {4'd0, ST_MEMWR});
    reset = 1'b1;
    step();
    chk("rs_state",    {4'd0, state}, 8'd0);
    chk("rs_memwrite", {7'd0, memwrite}, 8'd0);
    reset = 1'b0; mem_ready = 1'b1; opcode = 6'b000100;
    step();
    chk("beq_decode_state", {4'd0, state}, {4'd0, ST_DECODE});
    step();
    chk("beq_branch_state",   {4'd0, state}, {4'd0, ST_BRANCH});
    chk("beq_branch_aluop",   {6'd0, aluop}, 8'd1);
    chk("beq_branch_branch",  {7'd0, branch}, 8'd1);
    chk("beq_branch_pcsrc",   {6'd0, pcsrc}, 8'd1);
    chk("beq_branch_alusrca", {7'd0, alusrca}, 8'd1);
    step();
    chk("beq_done_state",  {4'd0, state}, 8'd0);
    chk("beq_done_branch", {7'd0, branch}, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
